// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  // Default memory geometry: 16 words of 8 bits
  localparam int ARB_AW = 4;
  localparam int ARB_DW = 8;

  // Master identifiers, also used as the round-robin pointer value
  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  // Arbiter FSM; encodings 2 and 3 are unused and fall back to idle
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; the master modport is the
// requester/memory side (the surrounding top level or a testbench).
interface mem_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
) ();

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_w;
  logic          mem_we;
  logic [DW-1:0] mem_data_r;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_address, mem_data_w, mem_we,
    input  mem_data_r
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_address, mem_data_w, mem_we,
    output mem_data_r
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select. The pointer holder wins a tie, a lone
// requester always wins, and after every grant the pointer moves to the
// master that was not granted.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_grant,
  output logic       o_winner
);

  logic r_ptr;

  // Pick the winner from the current requests and the priority pointer
  always_comb begin
    o_winner = M_CPU;
    if (i_req == 2'b11) begin
      o_winner = r_ptr;
    end else if (i_req[1]) begin
      o_winner = M_AUX;
    end
  end

  // Hand priority to the loser whenever a grant is actually issued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= M_CPU;
    end else if (i_grant) begin
      r_ptr <= ~o_winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port memory between the cpu (master 0) and the aux
// requester (master 1). One access every two cycles: the grant cycle drives
// the registered memory port, the following cycle returns read data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic        clk,
  input  logic        reset_n,
  mem_arbiter_if.slave bus,
  output logic [1:0]  dbg_state,
  output logic        dbg_owner,
  output logic [7:0]  dbg_gnt_cnt0,
  output logic [7:0]  dbg_gnt_cnt1
);

  arb_state_e    r_state;
  logic          r_owner;
  logic [1:0]    r_gnt;
  logic [1:0]    r_rvalid;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic [7:0]    r_cnt0;
  logic [7:0]    r_cnt1;

  logic [1:0]    w_req;
  logic          w_winner;
  logic          w_grant;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  assign w_req   = {bus.m1_req, bus.m0_req};
  assign w_grant = (r_state == ARB_IDLE) && (|w_req);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (w_req),
    .i_grant  (w_grant),
    .o_winner (w_winner)
  );

  // Route the winning master's access fields toward the memory port registers
  always_comb begin
    w_sel_we    = bus.m0_we;
    w_sel_addr  = bus.m0_addr;
    w_sel_wdata = bus.m0_wdata;
    if (w_winner == M_AUX) begin
      w_sel_we    = bus.m1_we;
      w_sel_addr  = bus.m1_addr;
      w_sel_wdata = bus.m1_wdata;
    end
  end

  // Arbiter FSM: IDLE grants and drives the memory port, ACCESS completes it.
  // A write is still flagged by r_mem_we during ACCESS, so its inverse marks a read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ARB_IDLE;
      r_owner     <= M_CPU;
      r_gnt       <= 2'b00;
      r_rvalid    <= 2'b00;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_cnt0      <= 8'd0;
      r_cnt1      <= 8'd0;
    end else begin
      r_gnt    <= 2'b00;
      r_rvalid <= 2'b00;
      r_mem_we <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (|w_req) begin
            r_mem_addr      <= w_sel_addr;
            r_mem_wdata     <= w_sel_wdata;
            r_mem_we        <= w_sel_we;
            r_gnt[w_winner] <= 1'b1;
            r_owner         <= w_winner;
            if (w_winner == M_AUX) begin
              r_cnt1 <= r_cnt1 + 8'd1;
            end else begin
              r_cnt0 <= r_cnt0 + 8'd1;
            end
            r_state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (!r_mem_we) begin
            if (r_owner == M_AUX) begin
              r_rdata1    <= bus.mem_data_r;
              r_rvalid[1] <= 1'b1;
            end else begin
              r_rdata0    <= bus.mem_data_r;
              r_rvalid[0] <= 1'b1;
            end
          end
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.m0_gnt      = r_gnt[0];
  assign bus.m1_gnt      = r_gnt[1];
  assign bus.m0_rvalid   = r_rvalid[0];
  assign bus.m1_rvalid   = r_rvalid[1];
  assign bus.m0_rdata    = r_rdata0;
  assign bus.m1_rdata    = r_rdata1;
  assign bus.mem_address = r_mem_addr;
  assign bus.mem_data_w  = r_mem_wdata;
  assign bus.mem_we      = r_mem_we;

  assign dbg_state    = r_state;
  assign dbg_owner    = r_owner;
  assign dbg_gnt_cnt0 = r_cnt0;
  assign dbg_gnt_cnt1 = r_cnt1;

endmodule
